mem_wb_pipe_stage: RTL and testbench
====================================

Name: mem_wb_pipe_stage

Overview:
Parametrised MEM/WB pipeline stage that replaces the plain always-latching MEM/WB register. It adds valid/ready flow control with a 2-entry skid buffer, synchronous flush and asynchronous reset. It also provides a built-in write-back select and a forwarding tap toward EX. It sits between the data-memory stage and the register-file write port.

Parameters:
DATA_W, 32, width of read_data, address and write-back data
REG_ADDR_W, 5, width of destination register index
ZERO_REG_PROTECT, 1, when 1 a capture with destination 0 forces reg_write to 0

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous kill of all held entries
in_valid  in  1  MEM stage presents an entry
in_ready  out  1  stage can accept an entry this cycle
reg_write_in  in  1  entry writes the register file
mem_to_reg_in  in  1  1 = write-back from read_data, 0 = from address
read_data_in  in  DATA_W  data-memory load result
address_in  in  DATA_W  ALU result / memory address
write_back_destination_in  in  REG_ADDR_W  destination register index
out_valid  out  1  output entry present
out_ready  in  1  WB consumes the output entry this cycle
reg_write_out  out  1  reg_write of output entry, qualified by out_valid
mem_to_reg_out  out  1  mem_to_reg of output entry
read_data_out  out  DATA_W  held read_data
address_out  out  DATA_W  held address
write_back_destination_out  out  REG_ADDR_W  held destination
wb_data_out  out  DATA_W  mem_to_reg_out ? read_data_out : address_out
fwd_valid  out  1  out_valid & reg_write_out
occupancy  out  2  entries held, 0..2

Behaviour:
- Storage: main slot (drives outputs) and skid slot. Each holds valid plus payload {reg_write, mem_to_reg, read_data, address, dest}.
- Reset (rst=1, async): both valid bits 0 and all payload bits 0. Therefore out_valid=0, reg_write_out=0, mem_to_reg_out=0, data/address/dest/wb_data_out=0, fwd_valid=0, occupancy=0, in_ready=1.
- in_ready = !skid_valid. It is a registered-state function only; there is no combinational path from out_ready.
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- States, encoded by {main_valid, skid_valid}:
  - EMPTY (0,0): accept -> load main, go to ONE.
  - ONE (1,0):
    - accept & consume -> load main with new entry, stay ONE.
    - accept only -> load skid, go to TWO.
    - consume only -> go to EMPTY.
    - neither -> hold.
  - TWO (1,1), in_ready=0:
    - consume -> main <= skid, skid_valid <= 0, go to ONE.
    - otherwise hold.
- Latency: 1 cycle, input edge to output, when the stage is empty or consuming. Throughput is 1 entry/cycle while out_ready=1.
- Ordering is strict FIFO. Data never bypasses an older held entry.
- ZERO_REG_PROTECT=1: reg_write is stored as reg_write_in & (write_back_destination_in != 0). This applies on load into either slot.
- reg_write_out = main.reg_write & main_valid. The remaining payload outputs show the held payload even when out_valid=0; consumers must qualify them.
- wb_data_out and fwd_valid are combinational from main-slot registers only.
- flush=1 at an edge clears both valid bits and drops any same-cycle accept. Payload is not cleared. flush has priority over accept, consume and skid transfer. in_ready during a flush cycle follows current state; an accepted handshake in that cycle is discarded.
- occupancy = main_valid + skid_valid.
- rst asserted mid-operation: state goes to EMPTY immediately, independent of clk. Deassertion is synchronous to the environment; the first accept is possible on the first edge after release.
- Invariant: skid_valid=1 implies main_valid=1. The bench asserts this every cycle.

Test Plan:
- Reset then stream: out_ready=1; push A (dest=3, address=0x10, mem_to_reg=0), then B (dest=4, read_data=0xDEAD, mem_to_reg=1) on consecutive cycles -> out_valid the cycle after each push; wb_data_out=0x10 then 0xDEAD; reg_write_out=1; occupancy stays 1.
- Backpressure: out_ready=0; push A, B, C on consecutive cycles -> occupancy 1, then 2; in_ready=0 after B; C is not accepted. Raise out_ready -> outputs A, B, then C (re-presented) in order, no loss or duplication.
- Zero-register guard: push reg_write_in=1, dest=0 -> reg_write_out=0, fwd_valid=0. With ZERO_REG_PROTECT=0 -> reg_write_out=1.
- Flush: occupancy=2 and in_valid=1 with flush=1 -> next cycle out_valid=0, occupancy=0, in_ready=1; the same-cycle input never appears.
- Async reset mid-stream: assert rst between clock edges with occupancy=2 -> out_valid, reg_write_out and occupancy are 0 before the next edge; all payload outputs are 0.
- Width parameterisation: DATA_W=64, REG_ADDR_W=6; push address=0xFFFF_0000_0000_0001, dest=63 -> values are reproduced exactly on address_out, wb_data_out and write_back_destination_out.

Source files
------------

// File: rtl/mem_wb_pipe_stage.sv
// MEM/WB pipeline stage: valid/ready register with a 2-entry skid buffer,
// synchronous flush, write-back select and a forwarding tap toward EX.
module mem_wb_pipe_stage #(
    parameter int DATA_W           = 32,
    parameter int REG_ADDR_W       = 5,
    parameter int ZERO_REG_PROTECT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  reg_write_in,
    input  logic                  mem_to_reg_in,
    input  logic [DATA_W-1:0]     read_data_in,
    input  logic [DATA_W-1:0]     address_in,
    input  logic [REG_ADDR_W-1:0] write_back_destination_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  reg_write_out,
    output logic                  mem_to_reg_out,
    output logic [DATA_W-1:0]     read_data_out,
    output logic [DATA_W-1:0]     address_out,
    output logic [REG_ADDR_W-1:0] write_back_destination_out,
    output logic [DATA_W-1:0]     wb_data_out,
    output logic                  fwd_valid,
    output logic [1:0]            occupancy
);

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [DATA_W-1:0]     read_data;
        logic [DATA_W-1:0]     address;
        logic [REG_ADDR_W-1:0] dest;
    } payload_t;

    // State is the pair {main_valid, skid_valid}; 2'b01 is unreachable.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_TWO   = 2'b11;

    logic     main_valid;
    logic     skid_valid;
    logic     main_valid_d;
    logic     skid_valid_d;
    logic     load_main_in;
    logic     load_main_skid;
    logic     load_skid_in;
    logic     accept;
    logic     consume;
    logic     dest_nonzero;
    logic [1:0] state;
    payload_t in_payload;
    payload_t main_q;
    payload_t skid_q;

    assign state = {main_valid, skid_valid};

    // Handshake: a transfer happens on a rising edge where valid & ready are
    // both high. in_ready depends only on registered state (never on
    // out_ready); out_valid never drops until its entry is consumed or flushed.
    assign in_ready = !skid_valid;
    assign accept   = in_valid & in_ready;
    assign consume  = main_valid & out_ready;

    assign dest_nonzero = |write_back_destination_in;

    always_comb begin
        in_payload            = '0;
        in_payload.reg_write  = reg_write_in;
        in_payload.mem_to_reg = mem_to_reg_in;
        in_payload.read_data  = read_data_in;
        in_payload.address    = address_in;
        in_payload.dest       = write_back_destination_in;
        if (ZERO_REG_PROTECT != 0) begin
            in_payload.reg_write = reg_write_in & dest_nonzero;
        end
    end

    always_comb begin
        main_valid_d   = main_valid;
        skid_valid_d   = skid_valid;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    main_valid_d = 1'b1;
                    load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && consume) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    skid_valid_d = 1'b1;
                    load_skid_in = 1'b1;
                end else if (consume) begin
                    main_valid_d = 1'b0;
                end
            end
            ST_TWO: begin
                if (consume) begin
                    skid_valid_d   = 1'b0;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                main_valid_d = 1'b0;
                skid_valid_d = 1'b0;
            end
        endcase
        // Flush wins over everything; any same-cycle handshake is dropped.
        if (flush) begin
            main_valid_d   = 1'b0;
            skid_valid_d   = 1'b0;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid_in   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            main_valid <= main_valid_d;
            skid_valid <= skid_valid_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_payload;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid_in) begin
                skid_q <= in_payload;
            end
        end
    end

    assign out_valid                  = main_valid;
    assign reg_write_out              = main_q.reg_write & main_valid;
    assign mem_to_reg_out             = main_q.mem_to_reg;
    assign read_data_out              = main_q.read_data;
    assign address_out                = main_q.address;
    assign write_back_destination_out = main_q.dest;
    assign wb_data_out                = main_q.mem_to_reg ? main_q.read_data : main_q.address;
    assign fwd_valid                  = main_valid & main_q.reg_write;
    assign occupancy                  = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Directed bench for mem_wb_pipe_stage: default, unprotected and 64-bit instances.
module tb_mem_wb_pipe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic        reg_write_in;
    logic        mem_to_reg_in;
    logic [31:0] read_data_in;
    logic [31:0] address_in;
    logic [4:0]  dest_in;

    logic        in_ready, out_valid, reg_write_out, mem_to_reg_out, fwd_valid;
    logic [31:0] read_data_out, address_out, wb_data_out;
    logic [4:0]  dest_out;
    logic [1:0]  occupancy;

    logic        nz_in_ready, nz_out_valid, nz_reg_write_out, nz_mem_to_reg_out, nz_fwd_valid;
    logic [31:0] nz_read_data_out, nz_address_out, nz_wb_data_out;
    logic [4:0]  nz_dest_out;
    logic [1:0]  nz_occupancy;

    logic        w_in_valid, w_out_ready, w_reg_write_in, w_mem_to_reg_in;
    logic [63:0] w_read_data_in, w_address_in;
    logic [5:0]  w_dest_in;
    logic        w_in_ready, w_out_valid, w_reg_write_out, w_mem_to_reg_out, w_fwd_valid;
    logic [63:0] w_read_data_out, w_address_out, w_wb_data_out;
    logic [5:0]  w_dest_out;
    logic [1:0]  w_occupancy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_wb_pipe_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
        .read_data_in(read_data_in), .address_in(address_in),
        .write_back_destination_in(dest_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
        .read_data_out(read_data_out), .address_out(address_out),
        .write_back_destination_out(dest_out),
        .wb_data_out(wb_data_out), .fwd_valid(fwd_valid), .occupancy(occupancy)
    );

    mem_wb_pipe_stage #(.ZERO_REG_PROTECT(0)) dut_nz (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(nz_in_ready),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
        .read_data_in(read_data_in), .address_in(address_in),
        .write_back_destination_in(dest_in),
        .out_valid(nz_out_valid), .out_ready(out_ready),
        .reg_write_out(nz_reg_write_out), .mem_to_reg_out(nz_mem_to_reg_out),
        .read_data_out(nz_read_data_out), .address_out(nz_address_out),
        .write_back_destination_out(nz_dest_out),
        .wb_data_out(nz_wb_data_out), .fwd_valid(nz_fwd_valid), .occupancy(nz_occupancy)
    );

    mem_wb_pipe_stage #(.DATA_W(64), .REG_ADDR_W(6)) dut_w (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .reg_write_in(w_reg_write_in), .mem_to_reg_in(w_mem_to_reg_in),
        .read_data_in(w_read_data_in), .address_in(w_address_in),
        .write_back_destination_in(w_dest_in),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .reg_write_out(w_reg_write_out), .mem_to_reg_out(w_mem_to_reg_out),
        .read_data_out(w_read_data_out), .address_out(w_address_out),
        .write_back_destination_out(w_dest_out),
        .wb_data_out(w_wb_data_out), .fwd_valid(w_fwd_valid), .occupancy(w_occupancy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic mtr,
                         input logic [31:0] rd, input logic [31:0] addr, input logic [4:0] dst);
        in_valid      = v;
        reg_write_in  = rw;
        mem_to_reg_in = mtr;
        read_data_in  = rd;
        address_in    = addr;
        dest_in       = dst;
    endtask

    // A held skid entry implies a held main entry, so any occupancy means out_valid.
    always @(negedge clk) begin
        if (!rst) begin
            chk("invariant", 64'(out_valid), 64'(occupancy != 2'd0));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        w_in_valid = 1'b0; w_out_ready = 1'b0; w_reg_write_in = 1'b0; w_mem_to_reg_in = 1'b0;
        w_read_data_in = 64'h0; w_address_in = 64'h0; w_dest_in = 6'd0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_occupancy", 64'(occupancy), 64'(0));
        chk("rst_fwd_valid", 64'(fwd_valid), 64'(0));
        chk("rst_reg_write", 64'(reg_write_out), 64'(0));
        chk("rst_wb_data", 64'(wb_data_out), 64'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Streaming with out_ready high
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h1111, 32'h10, 5'd3);
        tick();
        chk("a_out_valid", 64'(out_valid), 64'(1));
        chk("a_wb_data", 64'(wb_data_out), 64'h10);
        chk("a_reg_write", 64'(reg_write_out), 64'(1));
        chk("a_fwd_valid", 64'(fwd_valid), 64'(1));
        chk("a_dest", 64'(dest_out), 64'(3));
        chk("a_occupancy", 64'(occupancy), 64'(1));
        drive(1'b1, 1'b1, 1'b1, 32'hDEAD, 32'h20, 5'd4);
        tick();
        chk("b_out_valid", 64'(out_valid), 64'(1));
        chk("b_wb_data", 64'(wb_data_out), 64'hDEAD);
        chk("b_mem_to_reg", 64'(mem_to_reg_out), 64'(1));
        chk("b_dest", 64'(dest_out), 64'(4));
        chk("b_occupancy", 64'(occupancy), 64'(1));
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        tick();
        chk("drain_out_valid", 64'(out_valid), 64'(0));
        chk("drain_occupancy", 64'(occupancy), 64'(0));

        // Backpressure: A, B fill the stage, C waits
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hA0, 5'd5);
        tick();
        chk("bp_a_occ", 64'(occupancy), 64'(1));
        chk("bp_a_in_ready", 64'(in_ready), 64'(1));
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hB0, 5'd6);
        tick();
        chk("bp_b_occ", 64'(occupancy), 64'(2));
        chk("bp_b_in_ready", 64'(in_ready), 64'(0));
        chk("bp_b_head", 64'(address_out), 64'hA0);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hC0, 5'd7);
        tick();
        chk("bp_c_occ", 64'(occupancy), 64'(2));
        chk("bp_c_head", 64'(address_out), 64'hA0);
        out_ready = 1'b1;
        tick();
        chk("bp_out_b", 64'(address_out), 64'hB0);
        chk("bp_out_b_dest", 64'(dest_out), 64'(6));
        chk("bp_out_b_occ", 64'(occupancy), 64'(1));
        chk("bp_out_b_in_ready", 64'(in_ready), 64'(1));
        tick();
        chk("bp_out_c", 64'(address_out), 64'hC0);
        chk("bp_out_c_occ", 64'(occupancy), 64'(1));
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        tick();
        chk("bp_empty", 64'(out_valid), 64'(0));

        // Zero-register guard
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h55, 5'd0);
        tick();
        chk("zr_out_valid", 64'(out_valid), 64'(1));
        chk("zr_reg_write", 64'(reg_write_out), 64'(0));
        chk("zr_fwd_valid", 64'(fwd_valid), 64'(0));
        chk("zr_nz_reg_write", 64'(nz_reg_write_out), 64'(1));
        chk("zr_nz_fwd_valid", 64'(nz_fwd_valid), 64'(1));
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        tick();

        // Flush with a full stage and a pending input
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h100, 5'd8);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h200, 5'd9);
        tick();
        chk("fl_full_occ", 64'(occupancy), 64'(2));
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h300, 5'd10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_out_valid", 64'(out_valid), 64'(0));
        chk("fl_occ", 64'(occupancy), 64'(0));
        chk("fl_in_ready", 64'(in_ready), 64'(1));
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        out_ready = 1'b1;
        tick();
        chk("fl_no_ghost", 64'(out_valid), 64'(0));
        // Flush coinciding with an accepted handshake discards it
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h400, 5'd11);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h500, 5'd12);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        chk("fl_acc_occ", 64'(occupancy), 64'(0));
        tick();
        chk("fl_acc_out_valid", 64'(out_valid), 64'(0));

        // Async reset with two entries held
        drive(1'b1, 1'b1, 1'b1, 32'h77, 32'h600, 5'd13);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h88, 32'h700, 5'd14);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        chk("ar_pre_occ", 64'(occupancy), 64'(2));
        #2 rst = 1'b1;
        #1;
        chk("ar_out_valid", 64'(out_valid), 64'(0));
        chk("ar_reg_write", 64'(reg_write_out), 64'(0));
        chk("ar_occ", 64'(occupancy), 64'(0));
        chk("ar_in_ready", 64'(in_ready), 64'(1));
        chk("ar_address", 64'(address_out), 64'h0);
        chk("ar_read_data", 64'(read_data_out), 64'h0);
        chk("ar_wb_data", 64'(wb_data_out), 64'h0);
        chk("ar_dest", 64'(dest_out), 64'(0));
        chk("ar_mem_to_reg", 64'(mem_to_reg_out), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h800, 5'd12);
        tick();
        chk("ar_first_valid", 64'(out_valid), 64'(1));
        chk("ar_first_addr", 64'(address_out), 64'h800);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        tick();

        // 64-bit data, 6-bit destination
        w_out_ready = 1'b1;
        w_in_valid = 1'b1; w_reg_write_in = 1'b1; w_mem_to_reg_in = 1'b0;
        w_read_data_in = 64'h0123_4567_89AB_CDEF;
        w_address_in = 64'hFFFF_0000_0000_0001;
        w_dest_in = 6'd63;
        tick();
        chk("w_address", w_address_out, 64'hFFFF_0000_0000_0001);
        chk("w_wb_data", w_wb_data_out, 64'hFFFF_0000_0000_0001);
        chk("w_dest", 64'(w_dest_out), 64'(63));
        chk("w_reg_write", 64'(w_reg_write_out), 64'(1));
        w_mem_to_reg_in = 1'b1;
        tick();
        chk("w_wb_load", w_wb_data_out, 64'h0123_4567_89AB_CDEF);
        w_in_valid = 1'b0;
        tick();
        chk("w_empty", 64'(w_out_valid), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
